// File: rtl/led_array_serial_rx.sv
// Serial LED-array link receiver: deserialises LSB-first ser_clk/ser_do
// frames that are delimited by idle time into parallel words in sys_clk.
//
// Ports:
//   sys_clk    : system clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   ser_clk    : transmitter serial clock (asynchronous)
//   ser_do     : transmitter serial data, valid while ser_clk high
//   data       : last good frame, held until the next good frame
//   data_valid : 1-cycle pulse when data is updated
//   frame_err  : 1-cycle pulse when a frame closes with a bad bit count
//   busy       : high while a frame is being received
//
// Build option: define LED_ARRAY_RX_DEGLITCH_EN to add a two-sample
// stability filter on the synchronised ser_clk (one extra cycle of
// edge latency; single-cycle pulses are rejected).
module led_array_serial_rx #(
    parameter int DATA_W           = 8,
    parameter int FRAME_BITS       = 10,
    parameter int IDLE_TIMEOUT_CYC = 64
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              ser_clk,
    input  logic              ser_do,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int TW = $clog2(IDLE_TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] CNT_DW  = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_FB  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_BITS + 1);
    localparam logic [TW-1:0] TMR_END = TW'(IDLE_TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        IDLE,
        RECV
    } state_t;

    state_t state_q, state_d;

    logic clk_s1, clk_s2;
    logic do_s1, do_s2;
    logic clk_e, do_e;
    logic clk_prev;
    logic rise, fall;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_in;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // Same synchroniser depth on clock and data keeps them aligned.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            do_s1  <= 1'b0;
            do_s2  <= 1'b0;
        end else begin
            clk_s1 <= ser_clk;
            clk_s2 <= clk_s1;
            do_s1  <= ser_do;
            do_s2  <= do_s1;
        end
    end

`ifdef LED_ARRAY_RX_DEGLITCH_EN
    logic clk_f;
    logic do_d;

    // clk_s1 is the next value of clk_s2: equal means the level has
    // been seen on two consecutive cycles. Data is delayed to match.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            clk_f <= 1'b0;
            do_d  <= 1'b0;
        end else begin
            if (clk_s1 == clk_s2) begin
                clk_f <= clk_s2;
            end
            do_d <= do_s2;
        end
    end

    assign clk_e = clk_f;
    assign do_e  = do_d;
`else
    assign clk_e = clk_s2;
    assign do_e  = do_s2;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            clk_prev <= 1'b0;
        end else begin
            clk_prev <= clk_e;
        end
    end

    assign rise = clk_e & ~clk_prev;
    assign fall = ~clk_e & clk_prev;

    // New bit enters at the MSB so the first bit ends up in bit 0.
    assign shift_in = (shift_q >> 1)
                    | (DATA_W'(do_e) << (DATA_W - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                timer_d = '0;
                if (fall) begin
                    shift_d = shift_in;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end else if (rise) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                // An edge always beats a coincident timeout.
                if (rise || fall) begin
                    timer_d = '0;
                    if (fall) begin
                        if (cnt_q < CNT_DW) begin
                            shift_d = shift_in;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (timer_q == TMR_END) begin
                    if (cnt_q == CNT_FB) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == RECV);

endmodule

// File: tb/tb_led_array_serial_rx.sv
// Bench for led_array_serial_rx: frame-level reference model of the
// serial link compared against the receiver outputs.
module tb_led_array_serial_rx;

    localparam int DW = 8;
    localparam int FB = 10;
    localparam int TO = 64;

`ifdef LED_ARRAY_RX_DEGLITCH_EN
    localparam bit DG = 1'b1;
`else
    localparam bit DG = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          ser_clk = 1'b0;
    logic          ser_do = 1'b0;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    led_array_serial_rx #(
        .DATA_W(DW),
        .FRAME_BITS(FB),
        .IDLE_TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .ser_clk(ser_clk),
        .ser_do(ser_do),
        .data(data),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Observed pulse history
    int            n_valid = 0;
    int            n_err = 0;
    logic [DW-1:0] vq[$];
    logic [DW-1:0] prev_data = '0;
    logic          prev_pulse = 1'b0;
    time           last_fall_t = 0;
    time           pulse_t = 0;

    // Expected state from the model
    int            exp_valid = 0;
    int            exp_err = 0;
    logic [DW-1:0] exp_data = '0;

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (data_valid || frame_err) begin
                n_tests++;
                if (data_valid && frame_err) begin
                    n_fail++;
                    $display("FAIL pulse_excl valid=%b err=%b",
                             data_valid, frame_err);
                end
                n_tests++;
                if (prev_pulse) begin
                    n_fail++;
                    $display("FAIL pulse_width got 2+ cycles want 1");
                end
                if (data_valid) begin
                    n_valid++;
                    vq.push_back(data);
                end
                if (frame_err) n_err++;
                pulse_t = $time;
            end
            if (data !== prev_data) begin
                n_tests++;
                if (!data_valid) begin
                    n_fail++;
                    $display("FAIL data_hold got=%h was=%h no valid",
                             data, prev_data);
                end
            end
        end
        prev_pulse = (data_valid || frame_err) && !rst;
        prev_data  = data;
    end

    // One ser_clk pulse per bit: 3 cycles high, 3 low. Optional extra
    // low time after bit gap_at, optional 1-cycle glitch after bit gl_at.
    task automatic drive(input int n, input logic [63:0] bits,
                         input int gap_at, input int gap_low,
                         input int gl_at);
        for (int i = 0; i < n; i++) begin
            ser_clk = 1'b1;
            ser_do  = bits[i];
            repeat (3) @(negedge sys_clk);
            ser_clk = 1'b0;
            last_fall_t = $time;
            if (i == gl_at) begin
                @(negedge sys_clk);
                ser_clk = 1'b1;
                @(negedge sys_clk);
                ser_clk = 1'b0;
                last_fall_t = $time;
                @(negedge sys_clk);
            end else begin
                repeat (3) @(negedge sys_clk);
            end
            if (i == gap_at) repeat (gap_low) @(negedge sys_clk);
        end
    endtask

    task automatic close_seg(input int cnt, input logic [63:0] seg);
        if (cnt == FB) begin
            exp_valid++;
            exp_data = seg[DW-1:0];
        end else if (cnt > 0) begin
            exp_err++;
        end
    endtask

    // Link-level model: count bits per idle-delimited segment.
    task automatic model(input int n, input logic [63:0] bits,
                         input int gap_at, input int gap_low,
                         input int gl_at);
        int          cnt = 0;
        logic [63:0] seg = '0;
        for (int i = 0; i < n; i++) begin
            seg[cnt] = bits[i];
            cnt++;
            if (i == gl_at && !DG) begin
                seg[cnt] = bits[i];
                cnt++;
            end
            if (i == gap_at && i != n - 1 && 3 + gap_low > TO) begin
                close_seg(cnt, seg);
                cnt = 0;
                seg = '0;
            end
        end
        close_seg(cnt, seg);
    endtask

    task automatic send(input int n, input logic [63:0] bits,
                        input int gap_at, input int gap_low,
                        input int gl_at);
        model(n, bits, gap_at, gap_low, gl_at);
        drive(n, bits, gap_at, gap_low, gl_at);
    endtask

    task automatic settle_check(input string name);
        repeat (TO + 20) @(negedge sys_clk);
        n_tests++;
        if (n_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s_valid_cnt got=%0d want=%0d",
                     name, n_valid, exp_valid);
        end
        n_tests++;
        if (n_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err_cnt got=%0d want=%0d",
                     name, n_err, exp_err);
        end
        n_tests++;
        if (data !== exp_data) begin
            n_fail++;
            $display("FAIL %s_data got=%h want=%h",
                     name, data, exp_data);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy got=%b want=0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({data, data_valid, frame_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got=%h/%b/%b/%b want=0",
                     data, data_valid, frame_err, busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        send(10, 64'h0A5, -1, 0, -1);
        repeat (TO + 20) @(negedge sys_clk);
        n_tests++;
        if (pulse_t - last_fall_t != (TO + 3 + DG) * 10) begin
            n_fail++;
            $display("FAIL latency got=%0d want=%0d",
                     (pulse_t - last_fall_t) / 10, TO + 3 + DG);
        end
        settle_check("basic");
    endtask

    task automatic test_bad_count();
        send(9, 64'h1FF, -1, 0, -1);
        settle_check("short");
        send(11, 64'h7FF, -1, 0, -1);
        settle_check("long");
    endtask

    task automatic test_back_to_back();
        int q0;
        q0 = vq.size();
        send(10, 64'h03C, -1, 0, -1);
        repeat (200) @(negedge sys_clk);
        send(10, 64'h0C3, -1, 0, -1);
        settle_check("b2b");
        n_tests++;
        if (vq.size() != q0 + 2) begin
            n_fail++;
            $display("FAIL b2b_nvalid got=%0d want=2", vq.size() - q0);
        end else begin
            n_tests++;
            if (vq[q0] !== 8'h3C || vq[q0+1] !== 8'hC3) begin
                n_fail++;
                $display("FAIL b2b_seq got=%h,%h want=3c,c3",
                         vq[q0], vq[q0+1]);
            end
        end
    endtask

    task automatic test_gap();
        send(10, 64'h2D6, 3, TO - 5, -1);
        settle_check("gap_short");
        send(10, 64'h15B, 3, TO + 10, -1);
        settle_check("gap_long");
    endtask

    task automatic test_mid_reset();
        int v0, e0;
        drive(5, 64'h015, -1, 0, -1);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy got=%b want=1", busy);
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if (data !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outs data=%h busy=%b want 0/0",
                     data, busy);
        end
        exp_data = '0;
        v0 = n_valid;
        e0 = n_err;
        #2 rst = 1'b0;
        repeat (TO + 20) @(negedge sys_clk);
        n_tests++;
        if (n_valid != v0 || n_err != e0) begin
            n_fail++;
            $display("FAIL midrst_pulses got=%0d/%0d want=0/0",
                     n_valid - v0, n_err - e0);
        end
        send(10, 64'h081, -1, 0, -1);
        settle_check("after_rst");
    endtask

    task automatic test_glitch();
        send(10, 64'h05A, 3, 0, 3);
        settle_check("glitch");
    endtask

    task automatic test_random();
        int          n;
        int          gat;
        int          glen;
        logic [63:0] b;
        for (int k = 0; k < 8; k++) begin
            n    = FB - 1 + $urandom_range(0, 3);
            if (n > FB + 1) n = FB;
            b    = {$urandom, $urandom};
            gat  = $urandom_range(0, n - 1);
            glen = $urandom_range(0, 40);
            send(n, b, gat, glen, -1);
            settle_check("rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_count();
        test_back_to_back();
        test_gap();
        test_mid_reset();
        test_glitch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
